// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and grant source.
// Also used by the CPU top level and the testbench monitor.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CPU_BUSY = 2'd1,
        ST_DMA_BUSY = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_CPU  = 2'd1,
        SRC_DMA  = 2'd2
    } gnt_src_e;

    // DMA wins when starved or when the CPU is not asking; CPU wins ties otherwise.
    function automatic gnt_src_e arbitrate(input logic cpu_req,
                                           input logic dma_req,
                                           input logic starved);
        gnt_src_e src;
        src = SRC_NONE;
        if (dma_req && (starved || !cpu_req)) begin
            src = SRC_DMA;
        end else if (cpu_req) begin
            src = SRC_CPU;
        end
        return src;
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of cycles the DMA port has waited; flags when it has
// waited long enough to override the CPU's default priority.
module dmem_arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic starved_o
);
    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority: the grant cycle also sees the request still high.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved_o = (cnt_q >= CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one fixed-latency data memory between the CPU MEM stage and a DMA
// loader port; stalls the CPU pipeline until its access completes.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic              dma_gnt_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_done_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    arb_state_e        state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              dma_done_q, dma_done_d;

    gnt_src_e gnt_src;
    logic     starved;
    logic     starve_inc;
    logic     starve_clr;
    logic     cpu_done;

    assign gnt_src    = arbitrate(cpu_req_i, dma_req_i, starved);
    assign starve_inc = dma_req_i && (state_q != ST_DMA_BUSY);
    assign starve_clr = (state_q == ST_IDLE) && (gnt_src == SRC_DMA);

    dmem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_i     (starve_inc),
        .clr_i     (starve_clr),
        .starved_o (starved)
    );

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        dma_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                if (gnt_src == SRC_DMA) begin
                    state_d     = ST_DMA_BUSY;
                    lat_d       = LAT_LOAD;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dma_we_i;
                    mem_addr_d  = dma_addr_i;
                    mem_wdata_d = dma_wdata_i;
                end else if (gnt_src == SRC_CPU) begin
                    state_d     = ST_CPU_BUSY;
                    lat_d       = LAT_LOAD;
                    mem_en_d    = 1'b1;
                    mem_we_d    = cpu_we_i;
                    mem_addr_d  = cpu_addr_i;
                    mem_wdata_d = cpu_wdata_i;
                end
            end
            ST_CPU_BUSY, ST_DMA_BUSY: begin
                if (lat_q == '0) begin
                    state_d  = ST_IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == ST_CPU_BUSY) begin
                        cpu_rdata_d = mem_rdata_i;
                    end else begin
                        dma_rdata_d = mem_rdata_i;
                        dma_done_d  = 1'b1;
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            dma_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            dma_done_q  <= dma_done_d;
        end
    end

    // Load data bypasses the capture register so the pipeline can advance
    // at the end of the completion cycle.
    assign cpu_done    = (state_q == ST_CPU_BUSY) && (lat_q == '0);
    assign cpu_stall_o = cpu_req_i && !cpu_done;
    assign cpu_rdata_o = cpu_done ? mem_rdata_i : cpu_rdata_q;

    assign dma_gnt_o   = (state_q == ST_DMA_BUSY);
    assign dma_rdata_o = dma_rdata_q;
    assign dma_done_o  = dma_done_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: MEM_LAT=2 instance for arbitration,
// starvation and reset; MEM_LAT=1 instance for back-to-back CPU accesses.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    typedef struct {
        gnt_src_e    src;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_load;
    always #5 clk = ~clk;

    // MEM_LAT=2 instance signals
    logic        c0_req, c0_we, c0_stall;
    logic [31:0] c0_addr, c0_wdata, c0_rdata;
    logic        d_req, d_we, d_gnt, d_done;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m0_en, m0_we;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    // MEM_LAT=1 instance signals
    logic        c1_req, c1_we, c1_stall;
    logic [31:0] c1_addr, c1_wdata, c1_rdata;
    logic        d1_req, d1_we, d1_gnt, d1_done;
    logic [31:0] d1_addr, d1_wdata, d1_rdata;
    logic        m1_en, m1_we;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;

    logic [31:0] mem0 [0:63];
    logic [31:0] mem1 [0:63];

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   stall0 = 0, gnt0 = 0, stall1 = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u0 (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(c0_req), .cpu_we_i(c0_we), .cpu_addr_i(c0_addr), .cpu_wdata_i(c0_wdata),
        .cpu_rdata_o(c0_rdata), .cpu_stall_o(c0_stall),
        .dma_req_i(d_req), .dma_we_i(d_we), .dma_addr_i(d_addr), .dma_wdata_i(d_wdata),
        .dma_gnt_o(d_gnt), .dma_rdata_o(d_rdata), .dma_done_o(d_done),
        .mem_en_o(m0_en), .mem_we_o(m0_we), .mem_addr_o(m0_addr), .mem_wdata_o(m0_wdata),
        .mem_rdata_i(m0_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u1 (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(c1_req), .cpu_we_i(c1_we), .cpu_addr_i(c1_addr), .cpu_wdata_i(c1_wdata),
        .cpu_rdata_o(c1_rdata), .cpu_stall_o(c1_stall),
        .dma_req_i(d1_req), .dma_we_i(d1_we), .dma_addr_i(d1_addr), .dma_wdata_i(d1_wdata),
        .dma_gnt_o(d1_gnt), .dma_rdata_o(d1_rdata), .dma_done_o(d1_done),
        .mem_en_o(m1_en), .mem_we_o(m1_we), .mem_addr_o(m1_addr), .mem_wdata_o(m1_wdata),
        .mem_rdata_i(m1_rdata)
    );

    // Memory models: data valid combinationally for the addressed word.
    assign m0_rdata = mem0[m0_addr[7:2]];
    assign m1_rdata = mem1[m1_addr[7:2]];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) begin
                mem0[i] <= 32'h0;
                mem1[i] <= 32'h0;
            end
            mem0[4] <= 32'hDEADBEEF;
            mem0[2] <= 32'hCAFEF00D;
            mem1[4] <= 32'hDEADBEEF;
        end else begin
            if (m0_en && m0_we) mem0[m0_addr[7:2]] <= m0_wdata;
            if (m1_en && m1_we) mem1[m1_addr[7:2]] <= m1_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic push0(input gnt_src_e src, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input int cyc);
        exp_t e;
        e.src = src; e.we = we; e.addr = addr; e.data = data; e.cyc = cyc;
        q0.push_back(e);
    endtask

    task automatic push1(input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input int cyc);
        exp_t e;
        e.src = SRC_CPU; e.we = we; e.addr = addr; e.data = data; e.cyc = cyc;
        q1.push_back(e);
    endtask

    // Monitor for the MEM_LAT=2 instance: CPU completion and DMA done events.
    always @(negedge clk) begin
        if (rst) begin
            stall0 = 0;
            gnt0   = 0;
        end else begin
            if (c0_req && c0_stall) stall0++;
            if (d_gnt) gnt0++;
            if (c0_req && !c0_stall) begin
                if (q0.size() == 0) begin
                    n_checks++;
                    $display("FAIL cpu0_unexpected: completion at addr 0x%08h with empty scoreboard", m0_addr);
                end else begin
                    e0 = q0.pop_front();
                    chk("cpu0_src", 32'(SRC_CPU), 32'(e0.src));
                    chk("cpu0_stall_cycles", 32'(stall0), 32'(e0.cyc));
                    chk("cpu0_addr", m0_addr, e0.addr);
                    if (e0.we) chk("cpu0_wdata", m0_wdata, e0.data);
                    else       chk("cpu0_rdata", c0_rdata, e0.data);
                    $display("cpu0 %s addr=0x%08h data=0x%08h stall=%0d", e0.we ? "WR" : "RD",
                             m0_addr, e0.we ? m0_wdata : c0_rdata, stall0);
                end
                stall0 = 0;
            end
            if (d_done) begin
                if (q0.size() == 0) begin
                    n_checks++;
                    $display("FAIL dma_unexpected: done pulse with empty scoreboard");
                end else begin
                    e0 = q0.pop_front();
                    chk("dma_src", 32'(SRC_DMA), 32'(e0.src));
                    chk("dma_gnt_cycles", 32'(gnt0), 32'(e0.cyc));
                    if (!e0.we) chk("dma_rdata", d_rdata, e0.data);
                    $display("dma  %s addr=0x%08h gnt_cycles=%0d rdata=0x%08h", e0.we ? "WR" : "RD",
                             e0.addr, gnt0, d_rdata);
                end
                gnt0 = 0;
            end
        end
    end

    // Monitor for the MEM_LAT=1 instance.
    always @(negedge clk) begin
        if (rst) begin
            stall1 = 0;
        end else begin
            if (c1_req && u1.state_q == ST_IDLE) chk("cpu1_idle_we", {31'b0, m1_we}, 32'h0);
            if (c1_req && c1_stall) stall1++;
            if (c1_req && !c1_stall) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    $display("FAIL cpu1_unexpected: completion at addr 0x%08h with empty scoreboard", m1_addr);
                end else begin
                    e1 = q1.pop_front();
                    chk("cpu1_stall_cycles", 32'(stall1), 32'(e1.cyc));
                    chk("cpu1_addr", m1_addr, e1.addr);
                    if (e1.we) chk("cpu1_wdata", m1_wdata, e1.data);
                    else       chk("cpu1_rdata", c1_rdata, e1.data);
                    $display("cpu1 %s addr=0x%08h data=0x%08h stall=%0d", e1.we ? "WR" : "RD",
                             m1_addr, e1.we ? m1_wdata : c1_rdata, stall1);
                end
                stall1 = 0;
            end
        end
    end

    task automatic cpu_op(input bit sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int  n = 0;
        bit  done = 1'b0;
        if (sel) begin
            c1_we = we; c1_addr = addr; c1_wdata = wdata; c1_req = 1'b1;
        end else begin
            c0_we = we; c0_addr = addr; c0_wdata = wdata; c0_req = 1'b1;
        end
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
            if (sel) done = c1_req && !c1_stall;
            else     done = c0_req && !c0_stall;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL cpu_timeout: access to 0x%08h never completed", addr);
        end
        @(posedge clk); #1;
        if (sel) c1_req = 1'b0;
        else     c0_req = 1'b0;
    endtask

    task automatic dma_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        while (!d_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        d_req = 1'b0;
        if (!d_done) begin
            n_checks++;
            $display("FAIL dma_timeout: access to 0x%08h never completed", addr);
        end else begin
            @(negedge clk);
            chk("dma_done_width", {31'b0, d_done}, 32'h0);
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mem_en"},    {31'b0, m0_en}, 32'h0);
        chk({tag, "_mem_we"},    {31'b0, m0_we}, 32'h0);
        chk({tag, "_mem_addr"},  m0_addr, 32'h0);
        chk({tag, "_mem_wdata"}, m0_wdata, 32'h0);
        chk({tag, "_dma_gnt"},   {31'b0, d_gnt}, 32'h0);
        chk({tag, "_dma_rdata"}, d_rdata, 32'h0);
        chk({tag, "_dma_done"},  {31'b0, d_done}, 32'h0);
        chk({tag, "_cpu_rdata"}, c0_rdata, 32'h0);
        chk({tag, "_state"},     32'(u0.state_q), 32'(ST_IDLE));
    endtask

    initial begin
        rst = 1'b1; mem_load = 1'b1;
        c0_req = 0; c0_we = 0; c0_addr = 0; c0_wdata = 0;
        c1_req = 0; c1_we = 0; c1_addr = 0; c1_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        d1_req = 0; d1_we = 0; d1_addr = 0; d1_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");
        mem_load = 1'b0;
        rst = 1'b0;

        // CPU read alone
        push0(SRC_CPU, 1'b0, 32'h10, 32'hDEADBEEF, 2);
        cpu_op(1'b0, 1'b0, 32'h10, 32'h0);

        // Simultaneous requests: CPU first, DMA on the next IDLE
        push0(SRC_CPU, 1'b1, 32'h04, 32'h00001234, 2);
        push0(SRC_DMA, 1'b0, 32'h08, 32'hCAFEF00D, 2);
        fork
            cpu_op(1'b0, 1'b1, 32'h04, 32'h00001234);
            dma_op(1'b0, 32'h08, 32'h0);
        join

        // DMA write then CPU read of the same word
        push0(SRC_DMA, 1'b1, 32'h20, 32'h000055AA, 2);
        dma_op(1'b1, 32'h20, 32'h000055AA);
        push0(SRC_CPU, 1'b0, 32'h20, 32'h000055AA, 2);
        cpu_op(1'b0, 1'b0, 32'h20, 32'h0);

        // Continuous CPU traffic: DMA overrides after starving; third CPU access stalls 5
        push0(SRC_CPU, 1'b0, 32'h10, 32'hDEADBEEF, 2);
        push0(SRC_CPU, 1'b0, 32'h04, 32'h00001234, 2);
        push0(SRC_DMA, 1'b0, 32'h10, 32'hDEADBEEF, 2);
        push0(SRC_CPU, 1'b0, 32'h20, 32'h000055AA, 5);
        fork
            begin
                cpu_op(1'b0, 1'b0, 32'h10, 32'h0);
                cpu_op(1'b0, 1'b0, 32'h04, 32'h0);
                cpu_op(1'b0, 1'b0, 32'h20, 32'h0);
            end
            dma_op(1'b0, 32'h10, 32'h0);
        join

        // Starvation count was cleared by the grant: CPU wins a fresh tie again
        push0(SRC_CPU, 1'b0, 32'h08, 32'hCAFEF00D, 2);
        push0(SRC_DMA, 1'b1, 32'h24, 32'h00000077, 2);
        fork
            cpu_op(1'b0, 1'b0, 32'h08, 32'h0);
            dma_op(1'b1, 32'h24, 32'h00000077);
        join

        // Reset during CPU_BUSY: everything clears at once, no completion follows
        c0_we = 1'b1; c0_addr = 32'h30; c0_wdata = 32'h0000AAAA; c0_req = 1'b1;
        @(posedge clk); #2;
        chk("pre_rst_busy", 32'(u0.state_q), 32'(ST_CPU_BUSY));
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        c0_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {31'b0, m0_en}, 32'h0);
        end
        chk("post_rst_no_write", mem0[12], 32'h0);
        @(posedge clk); #1;

        // MEM_LAT=1: back-to-back load/store/load, one stall cycle each
        push1(1'b0, 32'h10, 32'hDEADBEEF, 1);
        push1(1'b1, 32'h14, 32'h0000BEEF, 1);
        push1(1'b0, 32'h14, 32'h0000BEEF, 1);
        cpu_op(1'b1, 1'b0, 32'h10, 32'h0);
        cpu_op(1'b1, 1'b1, 32'h14, 32'h0000BEEF);
        cpu_op(1'b1, 1'b0, 32'h14, 32'h0);

        repeat (3) @(posedge clk);
        chk("sb0_empty", 32'(q0.size()), 32'h0);
        chk("sb1_empty", 32'(q1.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates one shared data memory between two requesters: the CPU MEM stage (load/store) and an external DMA/loader port used for test-image loading and result dump.
- Sequences each access through a fixed-latency memory.
- Gives the CPU a stall signal that holds the pipeline while its access is pending.
- Sits between the pipeline's EX/MEM register outputs and the data memory instance.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MEM_LAT, 2, memory access cycles (>=1); mem_rdata_i valid in last access cycle
STARVE_MAX, 4, DMA waiting cycles after which DMA beats CPU in arbitration

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
cpu_req_i  in  1  CPU access request (EX_MEM MemRead|MemWrite)
cpu_we_i  in  1  CPU write enable
cpu_addr_i  in  ADDR_W  CPU address
cpu_wdata_i  in  DATA_W  CPU store data
cpu_rdata_o  out  DATA_W  CPU load data
cpu_stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB gets bubble
dma_req_i  in  1  DMA request, held until dma_done_o
dma_we_i  in  1  DMA write enable
dma_addr_i  in  ADDR_W  DMA address
dma_wdata_i  in  DATA_W  DMA write data
dma_gnt_o  out  1  DMA access in progress
dma_rdata_o  out  DATA_W  DMA read data, registered
dma_done_o  out  1  one-cycle completion pulse
mem_en_o  out  1  memory access active
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- One clock (clk_i). Reset rst_i is asynchronous, active-high. While rst_i is high:
  - state=IDLE; latency counter=0; starvation counter=0.
  - All registered outputs are 0: mem_*, dma_gnt_o, dma_rdata_o, dma_done_o, captured cpu data.
- Reset mid-access aborts the access. No completion is signalled for it.
- FSM states: IDLE, CPU_BUSY, DMA_BUSY.
- IDLE arbitration, evaluated combinationally, takes effect at the clock edge:
  - DMA wins if dma_req_i and (starve >= STARVE_MAX or !cpu_req_i).
  - Otherwise CPU wins if cpu_req_i.
  - Otherwise stay in IDLE.
- On grant:
  - Latch we/addr/wdata of the winner into mem_we_o/mem_addr_o/mem_wdata_o.
  - Set mem_en_o=1; load latency counter with MEM_LAT-1; enter the BUSY state.
- BUSY: counter decrements each cycle. The cycle with counter==0 is the completion cycle. Next state is IDLE, which clears mem_en_o and mem_we_o.
  - Every access costs 1 arbitration cycle + MEM_LAT cycles.
  - A held write rewrites the same word for MEM_LAT edges; this is harmless.
- cpu_stall_o is combinational: cpu_req_i && !(state==CPU_BUSY && counter==0).
  - The CPU pipeline advances at the end of the completion cycle.
  - CPU load stall = MEM_LAT cycles.
- cpu_rdata_o: mem_rdata_i during the CPU completion cycle; otherwise the last captured CPU read value (register updated at completion).
- DMA completion:
  - dma_rdata_o <= mem_rdata_i at the end of the completion cycle.
  - dma_done_o is high for exactly the next cycle.
  - dma_gnt_o is high throughout DMA_BUSY.
- Starvation counter:
  - +1 each cycle dma_req_i is high and state!=DMA_BUSY; saturates at STARVE_MAX.
  - Cleared on DMA grant.
- A DMA requester keeping dma_req_i high in the dma_done_o cycle is a new request. It is arbitrated normally.
- A request dropped mid-BUSY does not abort the access; it completes.
- Simultaneous new requests with starve < STARVE_MAX: CPU first.

Decomposition:
- Shared package dmem_arb_pkg: state enum (IDLE/CPU_BUSY/DMA_BUSY) and grant-source encoding. It is shared with the CPU top and the testbench monitor.
- One natural sub-module: dmem_arb_starve_ctr, the saturating starvation counter with clear and threshold compare.

Test Plan:
1. Reset during CPU_BUSY (MEM_LAT=2): assert rst_i asynchronously -> all outputs 0 immediately; state IDLE; no completion follows.
2. CPU read alone: addr 0x10, memory holds 0xDEADBEEF -> cpu_stall_o high for 2 cycles, low in completion cycle; cpu_rdata_o=0xDEADBEEF in that cycle.
3. Both request in the same IDLE cycle: CPU write 0x1234 to 0x04, DMA read 0x08 -> CPU served first; DMA granted next IDLE; dma_done_o pulses 1 cycle after DMA completion.
4. CPU requests continuously, DMA request held (STARVE_MAX=4) -> DMA wins the first IDLE with starve >= 4; CPU stalls across the DMA access; counter clears on DMA grant.
5. DMA writes 0x000055AA to 0x20, then CPU reads 0x20 -> cpu_rdata_o=0x000055AA; dma_gnt_o high exactly 2 cycles.
6. MEM_LAT=1, CPU back-to-back load/store: every access is 2 cycles; cpu_stall_o high exactly 1 cycle per access; mem_we_o never high in IDLE.
